// File: rtl/cpu_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, step encoding,
// bus-source bit positions and the opcode-to-class decode.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int unsigned ROUT_HI    = 16;
    localparam int unsigned ROUT_LO    = 17;
    localparam int unsigned ROUT_ZHIGH = 18;
    localparam int unsigned ROUT_ZLOW  = 19;
    localparam int unsigned ROUT_PC    = 20;
    localparam int unsigned ROUT_MDR   = 21;
    localparam int unsigned ROUT_INP   = 22;
    localparam int unsigned ROUT_CSE   = 23;

    typedef enum logic [3:0] {
        S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        C_ALU3, C_IMM, C_LDI, C_UNARY, C_MULDIV, C_LD, C_ST,
        C_MFHI, C_MFLO, C_HALT, C_NOP
    } class_e;

    function automatic class_e classify(input logic [4:0] opc);
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:    classify = C_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:   classify = C_IMM;
            OP_LDI:                     classify = C_LDI;
            OP_NEG, OP_NOT:             classify = C_UNARY;
            OP_MUL, OP_DIV:             classify = C_MULDIV;
            OP_LD:                      classify = C_LD;
            OP_ST:                      classify = C_ST;
            OP_MFHI:                    classify = C_MFHI;
            OP_MFLO:                    classify = C_MFLO;
            OP_HALT:                    classify = C_HALT;
            default:                    classify = C_NOP;
        endcase
    endfunction

endpackage

// File: rtl/reg_select.sv
// 4-bit register field to 16-bit one-hot select.
module reg_select (
    input  logic [3:0]  field_i,
    output logic [15:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        onehot_o[field_i] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0-T7 control unit: Moore FSM whose outputs decode from the step
// register and the IR fields; memory steps stall on mem_ready.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int ROUT_W = 25,
    parameter int OPC_W  = 5
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [31:0]       ir,
    input  logic              mem_ready,
    output logic [ROUT_W-1:0] Rout,
    output logic [15:0]       Rin,
    output logic              HIin,
    output logic              LOin,
    output logic              Zin,
    output logic              Yin,
    output logic              PCin,
    output logic              IRin,
    output logic              MARin,
    output logic              MDRin,
    output logic              IncPC,
    output logic              Read,
    output logic              Write,
    output logic [OPC_W-1:0]  alu_op,
    output logic              run,
    output logic [3:0]        step
);

    state_e            state_q, state_d;
    class_e            cls;
    logic [OPC_W-1:0]  opc;
    logic [15:0]       ra_oh, rb_oh, rc_oh;
    logic              unused_ir;

    assign opc       = ir[31:27];
    assign cls       = classify(opc);
    assign unused_ir = ^ir[14:0];
    assign step      = state_q;

    reg_select u_ra (.field_i(ir[26:23]), .onehot_o(ra_oh));
    reg_select u_rb (.field_i(ir[22:19]), .onehot_o(rb_oh));
    reg_select u_rc (.field_i(ir[18:15]), .onehot_o(rc_oh));

    always_ff @(posedge clock) begin
        if (!clear) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        Rout    = '0;
        Rin     = '0;
        HIin    = 1'b0;
        LOin    = 1'b0;
        Zin     = 1'b0;
        Yin     = 1'b0;
        PCin    = 1'b0;
        IRin    = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        alu_op  = '0;
        run     = 1'b1;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                Rout[ROUT_PC] = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Rout[ROUT_ZLOW] = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                if (mem_ready) state_d = S_T2;
            end
            S_T2: begin
                Rout[ROUT_MDR] = 1'b1; IRin = 1'b1;
                case (cls)
                    C_HALT:  state_d = S_HALT;
                    C_NOP:   state_d = S_T0;
                    default: state_d = S_T3;
                endcase
            end
            S_T3: begin
                state_d = S_T4;
                case (cls)
                    C_ALU3, C_IMM, C_LDI, C_LD, C_ST: begin
                        Rout[15:0] = rb_oh; Yin = 1'b1;
                    end
                    C_UNARY: begin
                        Rout[15:0] = rb_oh; alu_op = opc; Zin = 1'b1;
                    end
                    C_MULDIV: begin
                        Rout[15:0] = ra_oh; Yin = 1'b1;
                    end
                    C_MFHI: begin
                        Rout[ROUT_HI] = 1'b1; Rin = ra_oh; state_d = S_T0;
                    end
                    C_MFLO: begin
                        Rout[ROUT_LO] = 1'b1; Rin = ra_oh; state_d = S_T0;
                    end
                    default: state_d = S_T0;
                endcase
            end
            S_T4: begin
                state_d = S_T5;
                case (cls)
                    C_ALU3:   begin Rout[15:0] = rc_oh; alu_op = opc; Zin = 1'b1; end
                    C_IMM:    begin Rout[ROUT_CSE] = 1'b1; alu_op = opc; Zin = 1'b1; end
                    // Address arithmetic for ldi/ld/st always adds base and offset.
                    C_LDI, C_LD, C_ST: begin
                        Rout[ROUT_CSE] = 1'b1; alu_op = OP_ADD; Zin = 1'b1;
                    end
                    C_MULDIV: begin Rout[15:0] = rb_oh; alu_op = opc; Zin = 1'b1; end
                    C_UNARY:  begin Rout[ROUT_ZLOW] = 1'b1; Rin = ra_oh; state_d = S_T0; end
                    default:  state_d = S_T0;
                endcase
            end
            S_T5: begin
                state_d = S_T0;
                case (cls)
                    C_ALU3, C_IMM, C_LDI: begin Rout[ROUT_ZLOW] = 1'b1; Rin = ra_oh; end
                    C_MULDIV: begin Rout[ROUT_ZLOW] = 1'b1; LOin = 1'b1; state_d = S_T6; end
                    C_LD, C_ST: begin Rout[ROUT_ZLOW] = 1'b1; MARin = 1'b1; state_d = S_T6; end
                    default: ;
                endcase
            end
            S_T6: begin
                state_d = S_T0;
                case (cls)
                    C_MULDIV: begin Rout[ROUT_ZHIGH] = 1'b1; HIin = 1'b1; end
                    C_LD: begin
                        Read = 1'b1; MDRin = 1'b1;
                        state_d = mem_ready ? S_T7 : S_T6;
                    end
                    C_ST: begin Rout[15:0] = ra_oh; MDRin = 1'b1; state_d = S_T7; end
                    default: ;
                endcase
            end
            S_T7: begin
                state_d = S_T0;
                case (cls)
                    C_LD: begin Rout[ROUT_MDR] = 1'b1; Rin = ra_oh; end
                    C_ST: begin
                        Write = 1'b1;
                        state_d = mem_ready ? S_T0 : S_T7;
                    end
                    default: ;
                endcase
            end
            S_HALT: run = 1'b0;
            default: state_d = S_RESET;
        endcase
    end

endmodule
